// File: rtl/led_pkg.sv
// Shared widths, mode encodings, pattern constants and next-pattern rules for led_datapath.
package led_pkg;

  localparam int unsigned LED_W = 27;

  typedef logic [LED_W-1:0] led_t;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_R1   = 2'b01,
    MODE_R2   = 2'b10,
    MODE_AUTO = 2'b11
  } mode_e;

  localparam led_t R1_RIGHT = 27'h0000038;
  localparam led_t R1_LEFT  = 27'h0E00000;
  localparam led_t R2_START = 27'h4000001;
  localparam led_t R2_FULL  = 27'h7FFDFFF;
  localparam led_t LO_MASK  = 27'h0001FFF;
  localparam led_t HI_MASK  = 27'h7FFC000;

  // Rule 1: a 3-bit block bouncing between R1_RIGHT and R1_LEFT, held at an edge unless LR points inward.
  function automatic led_t rule1_next(input led_t cur, input logic lr);
    led_t nxt;
    if (cur == '0) begin
      nxt = R1_RIGHT;
    end else if (!lr) begin
      nxt = (cur == R1_LEFT) ? cur : led_t'(cur << 1);
    end else begin
      nxt = (cur == R1_RIGHT) ? cur : led_t'(cur >> 1);
    end
    return nxt;
  endfunction

  // Rule 2: both halves fill from the outer ends toward bit 13 (LR=0) or drain from the inside out (LR=1).
  function automatic led_t rule2_next(input led_t cur, input logic lr);
    led_t lo;
    led_t hi;
    led_t nxt;
    if (!lr) begin
      lo = led_t'((cur & LO_MASK) << 1) | led_t'(1);
      hi = led_t'((cur & HI_MASK) >> 1) | led_t'(led_t'(1) << (LED_W - 1));
    end else begin
      lo = led_t'((cur & LO_MASK) >> 1);
      hi = led_t'((cur & HI_MASK) << 1);
    end
    nxt = (lo & LO_MASK) | (hi & HI_MASK);
    if (!lr && (cur == '0)) begin
      nxt = R2_START;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/led_step_tick.sv
// Step prescaler: pulses tick on the enabled cycle where the count reaches STEP_DIV-1, then wraps.
module led_step_tick
  import led_pkg::*;
#(
  parameter int unsigned STEP_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  // Count only enabled cycles so a held datapath keeps its phase.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_datapath.sv
// LED pattern datapath: rule 1 bouncing block, rule 2 fill/drain, automatic hand-over mode.
// Optional step prescaler compiled in with `define LED_STEP_PRESCALE_EN.
module led_datapath
  import led_pkg::*;
#(
  parameter int unsigned STEP_DIV = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             LR,
  input  logic             switch_r1r2,
  input  logic             auto_rst,
  output logic [LED_W-1:0] leds,
  output logic             step
);

  logic  tick_c;
  led_t  leds_q;
  led_t  leds_d;
  led_t  pat_c;
  logic  step_q;
  logic  step_d;
  mode_e mode_q;
  mode_e mode_d;

`ifdef LED_STEP_PRESCALE_EN
  led_step_tick #(
    .STEP_DIV(STEP_DIV)
  ) u_step_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick_c)
  );
`else
  // Every enabled cycle steps; a zero divider is meaningless and disables stepping.
  assign tick_c = en && (STEP_DIV != 0);
`endif

  // Candidate pattern for the current mode.
  always_comb begin
    pat_c = leds_q;
    case (mode_q)
      MODE_OFF: pat_c = '0;
      MODE_R1:  pat_c = rule1_next(leds_q, LR);
      MODE_R2:  pat_c = rule2_next(leds_q, LR);
      MODE_AUTO: begin
        if (auto_rst) begin
          pat_c = switch_r1r2 ? led_t'(0) : R2_START;
        end else begin
          pat_c = switch_r1r2 ? rule2_next(leds_q, LR) : rule1_next(leds_q, LR);
        end
      end
      default: pat_c = '0;
    endcase
  end

  // A mode change clears the pattern and wins over a coincident tick.
  always_comb begin
    leds_d = leds_q;
    step_d = 1'b0;
    mode_d = mode_q;
    if (mode_e'(mode) != mode_q) begin
      mode_d = mode_e'(mode);
      leds_d = '0;
    end else if (tick_c) begin
      leds_d = pat_c;
      step_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      leds_q <= '0;
      step_q <= 1'b0;
      mode_q <= MODE_OFF;
    end else begin
      leds_q <= leds_d;
      step_q <= step_d;
      mode_q <= mode_d;
    end
  end

  assign leds = leds_q;
  assign step = step_q;

endmodule
